// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: bundles the NUM_PORTS requester streams and the shared
// downstream stream of axis_rr_arbiter.
//   master modport: arbiter side (drives s_axis_tready and the m_axis_* beat)
//   slave  modport: environment side (drives requester beats and m_axis_tready)
interface axis_rr_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS-1:0]            s_axis_tvalid;
    logic [NUM_PORTS-1:0]            s_axis_tlast;
    logic [NUM_PORTS-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic                            m_axis_tvalid;
    logic                            m_axis_tlast;
    logic [ID_W-1:0]                 m_axis_tid;
    logic                            m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin arbiter sharing one AXI4-Stream
// master port between NUM_PORTS requesters. A grant is held from arbitration
// until the granted port's tlast beat is accepted; one IDLE cycle separates
// packets. Every output beat carries its source index on m_axis_tid.
// Build option AXIS_ARB_OUTPUT_REG_EN: adds a 2-entry skid buffer on the master
// side, registering m_axis_* and removing the m_axis_tready -> s_axis_tready path.
module axis_rr_arbiter #(
    parameter int  NUM_PORTS  = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int ID_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input logic               aclk,
    input logic               aresetn,
    axis_rr_arbiter_if.master bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       pick;
    logic                  any_req;
    logic [DATA_WIDTH-1:0] s_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  s_rdy;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  busy, g_valid, g_last, g_ready, acc_last;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign s_data[i] = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign busy     = (state_q == BUSY);
    assign g_valid  = busy & bus.s_axis_tvalid[grant_q];
    assign g_last   = bus.s_axis_tlast[grant_q];
    assign g_data   = s_data[grant_q];
    // Packet ends when the granted port's tlast beat is taken on the slave side.
    assign acc_last = g_valid & g_ready & g_last;

    // First requester at or after ptr_q, wrapping at NUM_PORTS.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        pick    = ptr_q;
        any_req = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx_w = ID_W'(idx);
            if (!any_req && bus.s_axis_tvalid[idx_w]) begin
                any_req = 1'b1;
                pick    = idx_w;
            end
        end
    end

    // Next state: grant in IDLE, release and rotate on the packet's last beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (acc_last) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, rotation pointer and held grant.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Only the granted port ever sees ready.
    always_comb begin
        s_rdy          = '0;
        s_rdy[grant_q] = g_ready;
    end
    assign bus.s_axis_tready = s_rdy;

`ifdef AXIS_ARB_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [ID_W-1:0]       buf_id_q [2];
    logic [1:0]            buf_last_q;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  push, pop, m_valid;

    // Ready depends only on occupancy, so downstream ready never reaches s_axis_tready.
    assign g_ready = busy & (cnt_q != 2'd2);
    assign push    = g_valid & g_ready;
    assign m_valid = (cnt_q != 2'd0);
    assign pop     = m_valid & bus.m_axis_tready;

    // Buffer pointer and occupancy update.
    always_comb begin
        rd_d  = rd_q ^ pop;
        wr_d  = wr_q ^ push;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Buffer storage; cleared on reset so a held beat is dropped and outputs read zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= 2'd0;
            buf_last_q <= '0;
            for (int e = 0; e < 2; e++) begin
                buf_data_q[e] <= '0;
                buf_id_q[e]   <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push) begin
                buf_data_q[wr_q] <= g_data;
                buf_last_q[wr_q] <= g_last;
                buf_id_q[wr_q]   <= grant_q;
            end
        end
    end

    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = m_valid ? buf_data_q[rd_q] : '0;
    assign bus.m_axis_tlast  = m_valid & buf_last_q[rd_q];
    assign bus.m_axis_tid    = m_valid ? buf_id_q[rd_q] : '0;
`else
    // Pass-through: the granted port drives the master side directly.
    assign g_ready           = busy & bus.m_axis_tready;
    assign bus.m_axis_tvalid = g_valid;
    assign bus.m_axis_tdata  = busy ? g_data : '0;
    assign bus.m_axis_tlast  = busy & g_last;
    assign bus.m_axis_tid    = busy ? grant_q : '0;
`endif
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI4-Stream master port between NUM_PORTS AXI4-Stream slave requesters. It sits in the AXI_VIPs environment between the stream traffic sources and the single downstream stream sink. It locks a grant for a whole packet, which ends on the tlast beat, and tags every output beat with the source index on m_axis_tid.

## Interface
- NUM_PORTS, 4, number of slave requesters (1..16)
- DATA_WIDTH, 32, tdata width in bits per port
- ID_W, max(1,$clog2(NUM_PORTS)), width of m_axis_tid (derived, not overridden)

Ports:
- aclk  in  1  single clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  DATA_WIDTH  forwarded data
- m_axis_tvalid  out  1  forwarded valid
- m_axis_tlast  out  1  forwarded last
- m_axis_tid  out  ID_W  index of the source port for the current beat
- m_axis_tready  in  1  downstream ready

## Operation
- FSM states:
  - IDLE: no grant. All s_axis_tready=0. If any s_axis_tvalid=1, choose the first set index scanning ptr, ptr+1, … mod NUM_PORTS. Register it in grant. Go to BUSY.
  - BUSY: only s_axis_tready[grant] may be 1. It equals m_axis_tready when the output register slice is not built. Other readies stay 0.
  - In BUSY, a beat from port grant with tlast=1 is accepted on a cycle where s_axis_tvalid[grant] & s_axis_tready[grant] = 1. On that beat: next state IDLE, ptr <= (grant+1) mod NUM_PORTS.
- The grant persists through tvalid gaps inside a packet. Arbitration does not reoccur until tlast.
- Requests arriving in BUSY wait. No preemption, no timeout.
- NUM_PORTS=1: ptr stays 0 and the FSM still passes through IDLE between packets.
- m_axis_tid = grant for every beat emitted.
- Data, last and id pass unmodified. There is no width conversion.
- AXI4-Stream rules on the master side: once m_axis_tvalid=1, m_axis_tdata, m_axis_tlast, m_axis_tid and m_axis_tvalid stay stable until m_axis_tready=1.
- Reset (aresetn=0, any time including mid-packet):
  - immediately: state=IDLE, ptr=0, grant=0, any buffered beat discarded
  - outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0
  - a partially transferred packet is truncated. No recovery is attempted.

## Timing
- Arbitration latency is 1 cycle. tvalid is seen in IDLE at cycle N, and s_axis_tready[grant] can first be 1 in cycle N+1.
- There is exactly one bubble cycle (IDLE) between consecutive packets, even with back-to-back requests.
- Without the output slice:
  - m_axis_* is combinational from the granted port in BUSY.
  - Throughput is 1 beat/cycle within a packet.
- With the output slice:
  - There is one extra cycle of latency, input beat to m_axis_tvalid.
  - Throughput stays 1 beat/cycle.
  - s_axis_tready does not depend combinationally on m_axis_tready.
- In IDLE, m_axis_tvalid=0 unless the slice still holds a beat from the previous packet. The slice drains independently of the FSM.

## Configuration
- AXIS_ARB_OUTPUT_REG_EN:
  - Defined: a 2-entry skid buffer registers m_axis_tdata, m_axis_tlast, m_axis_tid and m_axis_tvalid.
  - s_axis_tready[grant] = buffer not full.
  - The tlast-accept event is measured at the slave side (beat entering the buffer).
- Undefined: combinational pass-through as above, no storage.

## Test plan
- Single packet: port 2 sends 4 beats 0xA0..0xA3, tlast on the 4th, m_axis_tready=1 throughout. Required response:
  - m_axis_tdata = 0xA0..0xA3 on consecutive cycles, starting 1 cycle after tvalid (2 with the slice)
  - m_axis_tid=2, m_axis_tlast only on 0xA3
- Fairness: ports 0,1,3 hold continuous 2-beat packets from reset. Required response:
  - packet order on m_axis_tid = 0,1,3,0,1,3
  - one idle cycle between packets
  - port 2 is never granted
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 3-beat packet on port 1. Required response: all 3 beats appear in order with no duplicates, and m_axis_* stays stable while m_axis_tready=0.
- Intra-packet gap: port 0 drops tvalid for 3 cycles mid-packet while port 1 requests. Required response: grant stays 0 until port 0's tlast, then port 1 is granted.
- Reset mid-packet: aresetn=0 after beat 2 of a 5-beat packet. Required response:
  - the same cycle, m_axis_tvalid=0 and all s_axis_tready=0
  - after release with port 3 requesting, grant=3 per ptr=0 scan and m_axis_tid=3
- NUM_PORTS=1: two back-to-back 1-beat packets. Required response: each is forwarded with m_axis_tid=0, separated by one idle cycle.
